// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int NUM_BITS = 32,
    parameter int OP_BITS  = 3,
    parameter int CNT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OP_BITS-1:0]  md_op,
    input  logic [NUM_BITS-1:0] data1,
    input  logic [NUM_BITS-1:0] data2,
    input  logic                flush,
    output logic                busy,
    output logic [NUM_BITS-1:0] hi,
    output logic [NUM_BITS-1:0] lo
);

    localparam logic [OP_BITS-1:0] OP_MULT  = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_MULTU = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_DIV   = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_DIVU  = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] OP_MTHI  = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] OP_MTLO  = OP_BITS'(6);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_nxt;

    logic [CNT_BITS-1:0]   cnt;
    logic [2*NUM_BITS-1:0] acc;
    logic [NUM_BITS-1:0]   rem;
    logic [NUM_BITS-1:0]   opb;
    logic                  is_div;
    logic                  neg_q;
    logic                  neg_r;

    logic                  op_mul, op_div, op_sgn;
    logic                  accept, last;
    logic                  sign1, sign2;
    logic [NUM_BITS-1:0]   mag1, mag2;
    logic [NUM_BITS:0]     add_sum;
    logic [NUM_BITS:0]     div_shift, div_trial;
    logic [2*NUM_BITS-1:0] prod;
    logic [NUM_BITS-1:0]   res_hi, res_lo;

    always_comb begin
        op_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
        op_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
        op_sgn = (md_op == OP_MULT) || (md_op == OP_DIV);
        accept = start && (state == IDLE) && (op_mul || op_div);
        sign1  = op_sgn && data1[NUM_BITS-1];
        sign2  = op_sgn && data2[NUM_BITS-1];
        mag1   = sign1 ? -data1 : data1;
        mag2   = sign2 ? -data2 : data2;
        last   = (cnt == CNT_BITS'(NUM_BITS - 1));
    end

    always_comb begin
        add_sum   = {1'b0, acc[2*NUM_BITS-1:NUM_BITS]}
                  + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {rem, acc[NUM_BITS-1]};
        div_trial = div_shift - {1'b0, opb};
        prod      = neg_q ? -acc : acc;
        if (is_div) begin
            res_lo = neg_q ? -acc[NUM_BITS-1:0] : acc[NUM_BITS-1:0];
            res_hi = neg_r ? -rem : rem;
        end else begin
            res_lo = prod[NUM_BITS-1:0];
            res_hi = prod[2*NUM_BITS-1:NUM_BITS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (flush) state_nxt = IDLE;
                     else if (last) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= op_div;
                        // Divide by zero keeps the all-ones quotient;
                        // the remainder restore alone yields data1.
                        neg_q  <= (sign1 ^ sign2) && !(op_div && data2 == '0);
                        neg_r  <= sign1;
                        rem    <= '0;
                        opb    <= op_div ? mag2 : mag1;
                        acc    <= {{NUM_BITS{1'b0}}, (op_div ? mag1 : mag2)};
                    end
                    if (start && md_op == OP_MTHI) hi <= data1;
                    if (start && md_op == OP_MTLO) lo <= data1;
                end
                CALC: begin
                    cnt <= cnt + CNT_BITS'(1);
                    if (is_div) begin
                        if (!div_trial[NUM_BITS])
                            rem <= div_trial[NUM_BITS-1:0];
                        else
                            rem <= div_shift[NUM_BITS-1:0];
                        acc[NUM_BITS-1:0] <= {acc[NUM_BITS-2:0],
                                              ~div_trial[NUM_BITS]};
                    end else begin
                        acc <= {add_sum, acc[NUM_BITS-1:1]};
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DIVU  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(
        .NUM_BITS(32),
        .OP_BITS (3),
        .CNT_BITS(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .md_op(md_op),
        .data1(data1),
        .data2(data2),
        .flush(flush),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_busy = 1'b0;
    int   busy_len = 0;
    logic [31:0] mh, ml;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation each time busy falls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else if (busy === 1'b1) begin
            busy_len++;
            prev_busy = 1'b1;
        end else if (prev_busy) begin
            prev_busy = 1'b0;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: hi %h lo %h", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                check("result_hi", hi, mon_e.hi);
                check("result_lo", lo, mon_e.lo);
                check("busy_cycles", 32'(busy_len), 32'(mon_e.len));
            end
            busy_len = 0;
        end
    end

    function automatic void ref_model(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] rh,
                                      output logic [31:0] rl);
        longint      sa, sbv, p;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        rh  = '0;
        rl  = '0;
        case (op)
            MULT: begin
                p  = sa * sbv;
                rh = p[63:32];
                rl = p[31:0];
            end
            MULTU: begin
                u  = {32'b0, a} * {32'b0, b};
                rh = u[63:32];
                rl = u[31:0];
            end
            DIV: begin
                if (b == 0) begin
                    rh = a;
                    rl = '1;
                end else begin
                    p  = sa / sbv;
                    rl = p[31:0];
                    p  = sa % sbv;
                    rh = p[31:0];
                end
            end
            DIVU: begin
                if (b == 0) begin
                    rh = a;
                    rl = '1;
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        md_op = op;
        data1 = a;
        data2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic issue_exp(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh,
                             input logic [31:0] el, input int len);
        exp_t e;
        e.hi  = eh;
        e.lo  = el;
        e.len = len;
        sb.push_back(e);
        drive(op, a, b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy %b required 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        md_op = 3'd0;
        data1 = '0;
        data2 = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(MTHI, 32'h12345678, 32'h0);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", 32'(busy), 32'd0);
        drive(MTLO, 32'h9ABCDEF0, 32'h0);
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_busy", 32'(busy), 32'd0);

        issue_exp(MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        check("mult_mid_hi", hi, 32'h12345678);
        wait_idle();
        issue_exp(MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 33);
        wait_idle();
        issue_exp(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        wait_idle();
        issue_exp(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        wait_idle();
        issue_exp(DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 33);
        wait_idle();
        issue_exp(DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33);
        wait_idle();
        issue_exp(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        wait_idle();

        issue_exp(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 33);
        repeat (8) @(posedge clk);
        #1;
        drive(DIVU, 32'd8, 32'd2);
        check("calc_hold_hi", hi, 32'h0);
        check("calc_hold_lo", lo, 32'h80000000);
        drive(MTHI, 32'hDEADBEEF, 32'h0);
        check("busy_mthi_ignored", hi, 32'h0);
        wait_idle();

        issue_exp(MULTU, 32'd7, 32'd9, 32'd0, 32'd15, 20);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);

        issue_exp(MULT, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 33);
        check("b2b_accept", 32'(busy), 32'd1);
        wait_idle();
        issue_exp(DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 33);
        check("b2b_accept2", 32'(busy), 32'd1);
        wait_idle();

        drive(DIV, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_hi", hi, 32'h0);
        check("async_rst_lo", lo, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_hi", hi, 32'h0);
        check("post_rst_lo", lo, 32'h0);
        mh = '0;
        ml = '0;

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            if (op <= DIVU) begin
                ref_model(op, a, b, eh, el);
                issue_exp(op, a, b, eh, el, 33);
                mh = eh;
                ml = el;
                wait_idle();
            end else begin
                drive(op, a, b);
                if (op == MTHI) mh = a;
                else ml = a;
                check("rand_mt_hi", hi, mh);
                check("rand_mt_lo", lo, ml);
            end
        end

        wait_idle();
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
